// File: rtl/rv32_operand_fetch_if.sv
// Bundle between decode, execute, write-back and the register file for
// rv32_operand_fetch: issue handshake, operand stage, write-back and RF ports.
interface rv32_operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            iss_valid;
    logic            iss_ready;
    logic [RA_W-1:0] iss_rs1;
    logic [RA_W-1:0] iss_rs2;
    logic [RA_W-1:0] iss_rd;
    logic            iss_rd_wen;

    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_rs1_data;
    logic [XLEN-1:0] op_rs2_data;
    logic [RA_W-1:0] op_rd;
    logic            op_rd_wen;

    logic            wb_valid;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    logic [RA_W-1:0] rf_ra1;
    logic [RA_W-1:0] rf_ra2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic            rf_wen;
    logic [RA_W-1:0] rf_wa;
    logic [XLEN-1:0] rf_wd;

    // environment side: decode, execute, write-back and register file
    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
        output op_ready, wb_valid, wb_rd, wb_data, flush,
        output rf_rd1, rf_rd2,
        input  iss_ready, op_valid, op_rs1_data, op_rs2_data,
        input  op_rd, op_rd_wen,
        input  rf_ra1, rf_ra2, rf_wen, rf_wa, rf_wd
    );

    // operand-fetch side
    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_rd_wen,
        input  op_ready, wb_valid, wb_rd, wb_data, flush,
        input  rf_rd1, rf_rd2,
        output iss_ready, op_valid, op_rs1_data, op_rs2_data,
        output op_rd, op_rd_wen,
        output rf_ra1, rf_ra2, rf_wen, rf_wa, rf_wd
    );
endinterface

// File: rtl/rv32_operand_fetch.sv
// RV32 operand fetch: RF read/write steering, RAW/WAW scoreboard, write-back
// bypass, one-entry valid/ready operand stage. Ports: clk, rst_n, bus (slave).
module rv32_operand_fetch #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    rv32_operand_fetch_if.slave bus
);
    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;
    logic            hazard;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;

    // a write-back landing this cycle releases its register early
    function automatic logic eb(
        input logic [NREG-1:0] s,
        input logic [RA_W-1:0] r,
        input logic            wv,
        input logic [RA_W-1:0] wr
    );
        return (r != '0) && s[r] && !(wv && wr == r);
    endfunction

    function automatic logic [XLEN-1:0] pick(
        input logic [RA_W-1:0] r,
        input logic [XLEN-1:0] rf,
        input logic            wv,
        input logic [RA_W-1:0] wr,
        input logic [XLEN-1:0] wd
    );
        if (r == '0) return '0;
        if (wv && wr == r) return wd;
        return rf;
    endfunction

    assign bus.rf_ra1 = bus.iss_rs1;
    assign bus.rf_ra2 = bus.iss_rs2;
    assign bus.rf_wen = bus.wb_valid;
    assign bus.rf_wa  = bus.wb_rd;
    assign bus.rf_wd  = bus.wb_data;

    always_comb begin
        hazard = eb(sb, bus.iss_rs1, bus.wb_valid, bus.wb_rd)
              || eb(sb, bus.iss_rs2, bus.wb_valid, bus.wb_rd)
              || (bus.iss_rd_wen
                  && eb(sb, bus.iss_rd, bus.wb_valid, bus.wb_rd));
        ready  = (!bus.op_valid || bus.op_ready) && !hazard && !bus.flush;
        accept = bus.iss_valid && ready;
        src1   = pick(bus.iss_rs1, bus.rf_rd1,
                      bus.wb_valid, bus.wb_rd, bus.wb_data);
        src2   = pick(bus.iss_rs2, bus.rf_rd2,
                      bus.wb_valid, bus.wb_rd, bus.wb_data);
    end

    assign bus.iss_ready = ready;

    // clears first, then the new claim, so a same-index set wins
    always_comb begin
        sb_next = sb;
        if (bus.wb_valid)
            sb_next[bus.wb_rd] = 1'b0;
        if (bus.flush && bus.op_valid && bus.op_rd_wen)
            sb_next[bus.op_rd] = 1'b0;
        if (accept && bus.iss_rd_wen)
            sb_next[bus.iss_rd] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb              <= '0;
            bus.op_valid    <= 1'b0;
            bus.op_rs1_data <= '0;
            bus.op_rs2_data <= '0;
            bus.op_rd       <= '0;
            bus.op_rd_wen   <= 1'b0;
        end else begin
            sb <= sb_next;
            if (accept) begin
                bus.op_valid    <= 1'b1;
                bus.op_rs1_data <= src1;
                bus.op_rs2_data <= src2;
                bus.op_rd       <= bus.iss_rd;
                bus.op_rd_wen   <= bus.iss_rd_wen;
            end else if (bus.flush || bus.op_ready) begin
                bus.op_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv32_operand_fetch.sv
// Scoreboard bench for rv32_operand_fetch: directed scenarios followed by
// random traffic checked against an architectural register/pending model.
module tb_rv32_operand_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rv32_operand_fetch_if #(.XLEN(32), .RA_W(5)) bus ();

    rv32_operand_fetch #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // external register file driven by the DUT's ports
    logic [31:0] rf [32];
    assign bus.rf_rd1 = rf[bus.rf_ra1];
    assign bus.rf_rd2 = rf[bus.rf_ra2];
    always @(posedge clk)
        if (bus.rf_wen && bus.rf_wa != 5'd0)
            rf[bus.rf_wa] <= bus.rf_wd;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        w;
    } item_t;

    item_t       exp_q[$];
    logic [4:0]  infl[$];
    bit          pend[32];
    logic [31:0] arch[32];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit busy_now(input logic [4:0] r, input logic wbv,
                                    input logic [4:0] wbrd);
        return r != 5'd0 && pend[r] && !(wbv && wbrd == r);
    endfunction

    // one clock of stimulus; model predicts iss_ready and what gets issued
    task automatic step(input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rdw, input logic ordy,
                        input logic wbv, input logic [4:0] wbrd,
                        input logic [31:0] wbd, input logic fl);
        bit    occ, hz, er;
        item_t it;
        @(posedge clk);
        #1;
        bus.iss_valid  = v;
        bus.iss_rs1    = rs1;
        bus.iss_rs2    = rs2;
        bus.iss_rd     = rd;
        bus.iss_rd_wen = rdw;
        bus.op_ready   = ordy;
        bus.wb_valid   = wbv;
        bus.wb_rd      = wbrd;
        bus.wb_data    = wbd;
        bus.flush      = fl;
        #1;
        occ = exp_q.size() != 0;
        chk("op_valid", {31'd0, bus.op_valid}, {31'd0, occ});
        hz = busy_now(rs1, wbv, wbrd) || busy_now(rs2, wbv, wbrd)
          || (rdw && busy_now(rd, wbv, wbrd));
        er = (!occ || ordy) && !hz && !fl;
        chk("iss_ready", {31'd0, bus.iss_ready}, {31'd0, er});
        if (wbv) begin
            if (wbrd != 5'd0) arch[wbrd] = wbd;
            pend[wbrd] = 1'b0;
            for (int i = 0; i < infl.size(); i++)
                if (infl[i] == wbrd) begin
                    infl.delete(i);
                    break;
                end
        end
        if (fl && occ) begin
            it = exp_q.pop_front();
            if (it.w) pend[it.rd] = 1'b0;
        end
        if (v && er) begin
            it.a  = (rs1 == 5'd0) ? 32'd0 : arch[rs1];
            it.b  = (rs2 == 5'd0) ? 32'd0 : arch[rs2];
            it.rd = rd;
            it.w  = rdw;
            exp_q.push_back(it);
            if (rdw && rd != 5'd0) pend[rd] = 1'b1;
        end
    endtask

    task automatic idle(input logic ordy);
        step(0, 0, 0, 0, 0, ordy, 0, 0, 0, 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        infl.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    endtask

    // monitor: compare every operand bundle execute consumes
    always @(negedge clk) begin
        item_t it;
        if (rst_n && bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_op actual=%0h required=none",
                         bus.op_rd);
            end else begin
                it = exp_q.pop_front();
                chk("op_rs1_data", bus.op_rs1_data, it.a);
                chk("op_rs2_data", bus.op_rs2_data, it.b);
                chk("op_rd", {27'd0, bus.op_rd}, {27'd0, it.rd});
                chk("op_rd_wen", {31'd0, bus.op_rd_wen}, {31'd0, it.w});
                if (it.w && it.rd != 5'd0) infl.push_back(it.rd);
            end
        end
    end

    logic        v, rdw, ordy, wbv, fl;
    logic [4:0]  rs1, rs2, rd, wbrd;
    logic [31:0] wbd;

    initial begin
        bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs2 = 0;
        bus.iss_rd = 0; bus.iss_rd_wen = 0; bus.op_ready = 0;
        bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.flush = 0;
        clear_model();
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("rst_op_rd", {27'd0, bus.op_rd}, 32'd0);
        chk("rst_op_rs1", bus.op_rs1_data, 32'd0);
        chk("rst_op_rs2", bus.op_rs2_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // preload every register through the write-back port
        for (int r = 1; r < 32; r++)
            step(0, 0, 0, 0, 0, 1, 1, 5'(r),
                 (r == 1) ? 32'h11 : (r == 2) ? 32'h22 : 32'h100 + r, 0);

        // basic issue, then RAW on x3 resolved by a bypassed write-back
        step(1, 1, 2, 3, 1, 1, 0, 0, 0, 0);
        idle(1);
        step(1, 3, 0, 4, 0, 1, 0, 0, 0, 0);
        step(1, 3, 0, 4, 0, 1, 1, 3, 32'h333, 0);

        // RAW on x5 stalls until write-back of 0xDEAD
        step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 5, 0, 0, 0, 1, 1, 5, 32'hDEAD, 0);

        // x0 destination never claims the scoreboard
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // backpressure for 4 cycles, then 3 independent at 1/cycle
        repeat (4) step(1, 1, 2, 6, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 10, 1, 1, 0, 0, 0, 0);
        step(1, 2, 1, 11, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 12, 1, 1, 0, 0, 0, 0);
        idle(1);

        // same-cycle clear and set of x7, then WAW stall
        step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 7, 1, 1, 1, 7, 32'h777, 0);
        step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        step(1, 7, 0, 7, 1, 1, 1, 7, 32'h7777, 0);

        // flush drops pending x9 and frees its scoreboard bit
        step(1, 1, 0, 9, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 9, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        // reset while stalled with a held operand stage
        step(1, 1, 0, 13, 1, 1, 0, 0, 0, 0);
        step(1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op_valid", {31'd0, bus.op_valid}, 32'd0);
        chk("mid_rst_op_rd", {27'd0, bus.op_rd}, 32'd0);
        chk("mid_rst_op_rd_wen", {31'd0, bus.op_rd_wen}, 32'd0);
        chk("mid_rst_op_rs1", bus.op_rs1_data, 32'd0);
        chk("mid_rst_op_rs2", bus.op_rs2_data, 32'd0);
        clear_model();
        bus.iss_valid = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step(1, 13, 12, 13, 1, 1, 0, 0, 0, 0);
        idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            v    = ($urandom % 4) != 0;
            rs1  = 5'($urandom_range(0, 7));
            rs2  = 5'($urandom_range(0, 7));
            rd   = 5'($urandom_range(0, 7));
            rdw  = ($urandom % 3) != 0;
            fl   = ($urandom % 25) == 0;
            ordy = fl ? 1'b0 : (($urandom % 4) != 0);
            wbv  = 0;
            wbrd = 0;
            wbd  = $urandom;
            if (infl.size() > 0 && ($urandom % 2) == 0) begin
                wbv  = 1;
                wbrd = infl[$urandom_range(0, infl.size() - 1)];
            end else if (($urandom % 5) == 0) begin
                wbrd = 5'($urandom_range(0, 31));
                wbv  = !pend[wbrd];
                if (!wbv) wbrd = 0;
            end
            step(v, rs1, rs2, rd, rdw, ordy, wbv, wbrd, wbd, fl);
        end

        // drain stage and retire every outstanding write
        repeat (3) idle(1);
        for (int k = 0; k < 40 && infl.size() > 0; k++)
            step(0, 0, 0, 0, 0, 1, 1, infl[0], $urandom, 0);
        chk("drain_queue", exp_q.size(), 32'd0);
        chk("drain_inflight", infl.size(), 32'd0);
        step(1, 1, 2, 3, 1, 1, 0, 0, 0, 0);
        idle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
